cfg_frame_queue: RTL and testbench

Parametrised configuration-frame assembler and queue between the FrontPanel config PipeIn and the SPI controller's config port. It gathers MSB-first pipe words into CFG_W-bit frames and accepts locally packed ASIC config words. Both sources feed one DEPTH-entry FIFO, which drains through a valid/ready handshake. This replaces single-frame, two-phase capture with multi-frame buffering, partial-frame timeout recovery, source arbitration and loss counters.

---
 rtl/cfg_frame_queue.sv | 187 ++++++++++++++++++
 tb/tb_cfg_frame_queue.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/cfg_frame_queue.sv
// Config frame assembler and FIFO: PipeIn words and ASIC frames share one queue
// drained by a valid/ready consumer; counts overflow and timed-out partials.
module cfg_frame_queue #(
    parameter int DATA_W  = 32,
    parameter int CFG_W   = 40,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic                         okClk,
    input  logic                         rst_we,
    input  logic [DATA_W-1:0]            pipe_data,
    input  logic                         pipe_write,
    input  logic [CFG_W-1:0]             asic_word,
    input  logic                         asic_load,
    input  logic                         flush,
    output logic [CFG_W-1:0]             cfg_word,
    output logic                         cfg_valid,
    input  logic                         cfg_ready,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         full,
    output logic                         assembling,
    output logic [15:0]                  overflow_cnt,
    output logic [7:0]                   partial_drop_cnt
);
    localparam int NW   = (CFG_W + DATA_W - 1) / DATA_W;
    localparam int SR_W = NW * DATA_W;
    localparam int IW   = $clog2(NW + 1);
    localparam int TW   = $clog2(TIMEOUT + 1);
    localparam int LW   = $clog2(DEPTH + 1);
    localparam int PW   = $clog2(DEPTH);

    typedef enum logic {IDLE, COLLECT} state_t;

    state_t          state, state_nx;
    logic [SR_W-1:0] sr, sr_nx, sr_shift;
    logic [IW-1:0]   idx, idx_nx;
    logic [TW-1:0]   tmo, tmo_nx;
    logic            frame_done, tmo_drop;

    logic [CFG_W-1:0] pend, pend_nx, push_word;
    logic             pend_v, pend_v_nx, push;

    logic [CFG_W-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic             pop, push_ok, drop;

    always_comb begin
        state_nx   = state;
        sr_nx      = sr;
        idx_nx     = idx;
        tmo_nx     = tmo;
        frame_done = 1'b0;
        tmo_drop   = 1'b0;
        sr_shift   = (sr << DATA_W) | SR_W'(pipe_data);
        unique case (state)
            IDLE: begin
                tmo_nx = '0;
                if (pipe_write) begin
                    sr_nx = SR_W'(pipe_data);
                    if (NW == 1) begin
                        frame_done = 1'b1;
                        idx_nx     = '0;
                    end else begin
                        state_nx = COLLECT;
                        idx_nx   = IW'(1);
                    end
                end
            end
            COLLECT: begin
                if (pipe_write) begin
                    sr_nx  = sr_shift;
                    tmo_nx = '0;
                    if (idx == IW'(NW - 1)) begin
                        frame_done = 1'b1;
                        idx_nx     = '0;
                        state_nx   = IDLE;
                    end else begin
                        idx_nx = idx + IW'(1);
                    end
                end else if (tmo == TW'(TIMEOUT - 1)) begin
                    tmo_drop = 1'b1;
                    state_nx = IDLE;
                    idx_nx   = '0;
                    tmo_nx   = '0;
                end else begin
                    tmo_nx = tmo + TW'(1);
                end
            end
            default: state_nx = IDLE;
        endcase
        if (flush) begin
            state_nx   = IDLE;
            idx_nx     = '0;
            tmo_nx     = '0;
            frame_done = 1'b0;
            tmo_drop   = 1'b0;
        end
    end

    // Pipe completion wins; a colliding ASIC frame waits one cycle in the slot.
    always_comb begin
        push      = 1'b0;
        push_word = sr_nx[CFG_W-1:0];
        pend_nx   = pend;
        pend_v_nx = pend_v;
        if (frame_done) begin
            push = 1'b1;
            if (asic_load) begin
                pend_v_nx = 1'b1;
                pend_nx   = asic_word;
            end
        end else if (pend_v) begin
            push      = 1'b1;
            push_word = pend;
            pend_v_nx = asic_load;
            if (asic_load) pend_nx = asic_word;
        end else if (asic_load) begin
            push      = 1'b1;
            push_word = asic_word;
        end
        if (flush) begin
            push      = 1'b0;
            pend_v_nx = 1'b0;
        end
    end

    assign cfg_valid  = (level != '0);
    assign full       = (level == LW'(DEPTH));
    assign cfg_word   = cfg_valid ? mem[rd_ptr] : '0;
    assign assembling = (state == COLLECT);

    assign pop     = cfg_valid && cfg_ready && !flush;
    assign push_ok = push && (!full || pop);
    assign drop    = push && full && !pop;

    always_ff @(posedge okClk or posedge rst_we) begin
        if (rst_we) begin
            state  <= IDLE;
            sr     <= '0;
            idx    <= '0;
            tmo    <= '0;
            pend   <= '0;
            pend_v <= 1'b0;
        end else begin
            state  <= state_nx;
            sr     <= sr_nx;
            idx    <= idx_nx;
            tmo    <= tmo_nx;
            pend   <= pend_nx;
            pend_v <= pend_v_nx;
        end
    end

    always_ff @(posedge okClk) begin
        if (push_ok) mem[wr_ptr] <= push_word;
    end

    always_ff @(posedge okClk or posedge rst_we) begin
        if (rst_we) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PW'(1);
            if (pop)     rd_ptr <= rd_ptr + PW'(1);
            if (push_ok && !pop)      level <= level + LW'(1);
            else if (pop && !push_ok) level <= level - LW'(1);
        end
    end

    // Loss counters survive flush and stick at all-ones.
    always_ff @(posedge okClk or posedge rst_we) begin
        if (rst_we) begin
            overflow_cnt     <= '0;
            partial_drop_cnt <= '0;
        end else begin
            if (drop && overflow_cnt != '1)
                overflow_cnt <= overflow_cnt + 16'd1;
            if (tmo_drop && partial_drop_cnt != '1)
                partial_drop_cnt <= partial_drop_cnt + 8'd1;
        end
    end
endmodule

// File: tb/tb_cfg_frame_queue.sv
// Directed vector bench for cfg_frame_queue: table of per-cycle stimulus and
// expected state, plus hand-written async reset and counter saturation runs.
module tb_cfg_frame_queue;
    logic        okClk;
    logic        rst_we;
    logic [31:0] pipe_data;
    logic        pipe_write;
    logic [39:0] asic_word;
    logic        asic_load;
    logic        flush;
    logic [39:0] cfg_word;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [2:0]  level;
    logic        full;
    logic        assembling;
    logic [15:0] overflow_cnt;
    logic [7:0]  partial_drop_cnt;

    cfg_frame_queue #(
        .DATA_W(32), .CFG_W(40), .DEPTH(4), .TIMEOUT(16)
    ) dut (
        .okClk(okClk), .rst_we(rst_we),
        .pipe_data(pipe_data), .pipe_write(pipe_write),
        .asic_word(asic_word), .asic_load(asic_load),
        .flush(flush), .cfg_word(cfg_word), .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready), .level(level), .full(full),
        .assembling(assembling), .overflow_cnt(overflow_cnt),
        .partial_drop_cnt(partial_drop_cnt)
    );

    initial okClk = 1'b0;
    always #5 okClk = ~okClk;

    typedef struct {
        logic        pw;
        logic [31:0] pd;
        logic        al;
        logic [39:0] aw;
        logic        fl;
        logic        rdy;
        logic        ev;
        logic [39:0] ew;
        logic [2:0]  el;
        logic        ef;
        logic        ea;
        logic [15:0] eo;
        logic [7:0]  ep;
    } vec_t;

    vec_t tv[$];
    int compared = 0;
    int mismatched = 0;

    function automatic vec_t mk(
        input logic pw, input logic [31:0] pd,
        input logic al, input logic [39:0] aw,
        input logic fl, input logic rdy,
        input logic ev, input logic [39:0] ew,
        input logic [2:0] el, input logic ef, input logic ea,
        input logic [15:0] eo, input logic [7:0] ep);
        vec_t v;
        v.pw = pw; v.pd = pd; v.al = al; v.aw = aw;
        v.fl = fl; v.rdy = rdy; v.ev = ev; v.ew = ew;
        v.el = el; v.ef = ef; v.ea = ea; v.eo = eo; v.ep = ep;
        return v;
    endfunction

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        pipe_write = 1'b0; pipe_data = '0;
        asic_load = 1'b0; asic_word = '0;
        flush = 1'b0; cfg_ready = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, ".valid"}, 64'(cfg_valid), 64'd0);
        check({tag, ".word"}, 64'(cfg_word), 64'd0);
        check({tag, ".level"}, 64'(level), 64'd0);
        check({tag, ".full"}, 64'(full), 64'd0);
        check({tag, ".asm"}, 64'(assembling), 64'd0);
        check({tag, ".ovf"}, 64'(overflow_cnt), 64'd0);
        check({tag, ".pdrop"}, 64'(partial_drop_cnt), 64'd0);
    endtask

    initial begin
        idle_inputs();
        rst_we = 1'b1;

        // single frame, immediate pop
        tv.push_back(mk(1, 32'h000000AB, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0));
        tv.push_back(mk(1, 32'h12345678, 0, 0, 0, 1, 1, 40'hAB12345678, 1, 0, 0, 0, 0));
        tv.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        // five frames into a 4-deep queue, then drain
        tv.push_back(mk(1, 32'h11, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        tv.push_back(mk(1, 32'h01010101, 0, 0, 0, 0, 1, 40'h1101010101, 1, 0, 0, 0, 0));
        tv.push_back(mk(1, 32'h12, 0, 0, 0, 0, 1, 40'h1101010101, 1, 0, 1, 0, 0));
        tv.push_back(mk(1, 32'h02020202, 0, 0, 0, 0, 1, 40'h1101010101, 2, 0, 0, 0, 0));
        tv.push_back(mk(1, 32'h13, 0, 0, 0, 0, 1, 40'h1101010101, 2, 0, 1, 0, 0));
        tv.push_back(mk(1, 32'h03030303, 0, 0, 0, 0, 1, 40'h1101010101, 3, 0, 0, 0, 0));
        tv.push_back(mk(1, 32'h14, 0, 0, 0, 0, 1, 40'h1101010101, 3, 0, 1, 0, 0));
        tv.push_back(mk(1, 32'h04040404, 0, 0, 0, 0, 1, 40'h1101010101, 4, 1, 0, 0, 0));
        tv.push_back(mk(1, 32'h15, 0, 0, 0, 0, 1, 40'h1101010101, 4, 1, 1, 0, 0));
        tv.push_back(mk(1, 32'h05050505, 0, 0, 0, 0, 1, 40'h1101010101, 4, 1, 0, 1, 0));
        tv.push_back(mk(0, 0, 0, 0, 0, 1, 1, 40'h1202020202, 3, 0, 0, 1, 0));
        tv.push_back(mk(0, 0, 0, 0, 0, 1, 1, 40'h1303030303, 2, 0, 0, 1, 0));
        tv.push_back(mk(0, 0, 0, 0, 0, 1, 1, 40'h1404040404, 1, 0, 0, 1, 0));
        tv.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0));
        tv.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0));
        // ASIC load colliding with a pipe completion, then uncontested
        tv.push_back(mk(1, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0));
        tv.push_back(mk(1, 32'h11223344, 1, 40'hC0FFEE0001, 0, 0, 1, 40'h0011223344, 1, 0, 0, 1, 0));
        tv.push_back(mk(0, 0, 0, 0, 0, 0, 1, 40'h0011223344, 2, 0, 0, 1, 0));
        tv.push_back(mk(0, 0, 0, 0, 0, 1, 1, 40'hC0FFEE0001, 1, 0, 0, 1, 0));
        tv.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0));
        tv.push_back(mk(0, 0, 1, 40'h123456789A, 0, 0, 1, 40'h123456789A, 1, 0, 0, 1, 0));
        tv.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0));
        // partial-frame timeout after 16 idle cycles
        tv.push_back(mk(1, 32'h55, 0, 0, 0, 1, 0, 0, 0, 0, 1, 1, 0));
        for (int i = 0; i < 15; i++)
            tv.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 1, 0));
        tv.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 1));
        tv.push_back(mk(1, 32'h01, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1));
        tv.push_back(mk(1, 32'h02, 0, 0, 0, 0, 1, 40'h0100000002, 1, 0, 0, 1, 1));
        tv.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 1));
        // fill, push+pop at full, flush with everything asserted
        tv.push_back(mk(0, 0, 1, 40'hA000000001, 0, 0, 1, 40'hA000000001, 1, 0, 0, 1, 1));
        tv.push_back(mk(0, 0, 1, 40'hA000000002, 0, 0, 1, 40'hA000000001, 2, 0, 0, 1, 1));
        tv.push_back(mk(0, 0, 1, 40'hA000000003, 0, 0, 1, 40'hA000000001, 3, 0, 0, 1, 1));
        tv.push_back(mk(0, 0, 1, 40'hA000000004, 0, 0, 1, 40'hA000000001, 4, 1, 0, 1, 1));
        tv.push_back(mk(0, 0, 1, 40'hA000000005, 0, 1, 1, 40'hA000000002, 4, 1, 0, 1, 1));
        tv.push_back(mk(1, 32'h77, 0, 0, 0, 1, 1, 40'hA000000003, 3, 0, 1, 1, 1));
        tv.push_back(mk(1, 32'h88, 1, 40'hA000000006, 1, 1, 0, 0, 0, 0, 0, 1, 1));
        tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
        // flush discards a pending ASIC frame
        tv.push_back(mk(1, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1));
        tv.push_back(mk(1, 32'h1, 1, 40'hBB00000000, 0, 0, 1, 40'h0000000001, 1, 0, 0, 1, 1));
        tv.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 1));
        tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1));

        #12;
        check_reset_vals("reset");
        @(negedge okClk);
        rst_we = 1'b0;
        @(posedge okClk);
        #1;

        for (int i = 0; i < tv.size(); i++) begin
            pipe_write = tv[i].pw; pipe_data = tv[i].pd;
            asic_load = tv[i].al; asic_word = tv[i].aw;
            flush = tv[i].fl; cfg_ready = tv[i].rdy;
            @(posedge okClk);
            #1;
            check($sformatf("v%0d.valid", i), 64'(cfg_valid), 64'(tv[i].ev));
            check($sformatf("v%0d.word", i), 64'(cfg_word), 64'(tv[i].ew));
            check($sformatf("v%0d.level", i), 64'(level), 64'(tv[i].el));
            check($sformatf("v%0d.full", i), 64'(full), 64'(tv[i].ef));
            check($sformatf("v%0d.asm", i), 64'(assembling), 64'(tv[i].ea));
            check($sformatf("v%0d.ovf", i), 64'(overflow_cnt), 64'(tv[i].eo));
            check($sformatf("v%0d.pdrop", i), 64'(partial_drop_cnt), 64'(tv[i].ep));
        end

        // async reset mid-frame with two frames queued
        idle_inputs();
        asic_load = 1'b1; asic_word = 40'hA1A1A1A1A1;
        @(posedge okClk); #1;
        asic_word = 40'hA2A2A2A2A2;
        @(posedge okClk); #1;
        asic_load = 1'b0;
        pipe_write = 1'b1; pipe_data = 32'hAB;
        @(posedge okClk); #1;
        idle_inputs();
        check("prerst.level", 64'(level), 64'd2);
        check("prerst.asm", 64'(assembling), 64'd1);
        #2;
        rst_we = 1'b1;
        #1;
        check_reset_vals("asyncrst");
        @(negedge okClk);
        @(negedge okClk);
        rst_we = 1'b0;
        @(posedge okClk); #1;
        pipe_write = 1'b1; pipe_data = 32'h000000AB;
        @(posedge okClk); #1;
        pipe_data = 32'h12345678;
        @(posedge okClk); #1;
        idle_inputs();
        check("postrst.valid", 64'(cfg_valid), 64'd1);
        check("postrst.word", 64'(cfg_word), 64'hAB12345678);
        check("postrst.level", 64'(level), 64'd1);
        check("postrst.pdrop", 64'(partial_drop_cnt), 64'd0);

        // partial-drop counter saturates at 0xFF
        for (int k = 0; k < 258; k++) begin
            pipe_write = 1'b1; pipe_data = '0;
            @(posedge okClk); #1;
            pipe_write = 1'b0;
            repeat (16) @(posedge okClk);
            #1;
            if (k == 0)
                check("sat.first", 64'(partial_drop_cnt), 64'd1);
        end
        check("sat.pdrop", 64'(partial_drop_cnt), 64'hFF);
        check("sat.asm", 64'(assembling), 64'd0);
        check("sat.level", 64'(level), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end
endmodule
